// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-master arbiter for the single-port data RAM.
// m0 is the core memory stage and m1 is a DMA or debug master. Grants are
// combinational and the burst history is registered. Each master has
// req/we/addr/data/sel inputs and gnt/rdata outputs, and m0 also gets a
// stall output. The o_ram_* outputs drive data_ram, and i_ram_data is its
// combinational read data.
// Optional MEM_ARB_LOCK_EN adds i_m1_lock, which lets m1 keep the RAM past
// MAX_BURST.
module data_mem_arbiter #(
  parameter int N_ADDR = 32,
  parameter int N_DATA = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [N_ADDR-1:0] i_m0_addr,
  input  logic [N_DATA-1:0] i_m0_data,
  input  logic [3:0]        i_m0_sel,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [N_ADDR-1:0] i_m1_addr,
  input  logic [N_DATA-1:0] i_m1_data,
  input  logic [3:0]        i_m1_sel,
`ifdef MEM_ARB_LOCK_EN
  input  logic              i_m1_lock,
`endif
  output logic              o_m0_gnt,
  output logic              o_m1_gnt,
  output logic [N_DATA-1:0] o_m0_rdata,
  output logic [N_DATA-1:0] o_m1_rdata,
  output logic              o_m0_stall,
  output logic              o_ram_ce,
  output logic              o_ram_we,
  output logic [N_ADDR-1:0] o_ram_addr,
  output logic [N_DATA-1:0] o_ram_data,
  output logic [3:0]        o_ram_sel,
  input  logic [N_DATA-1:0] i_ram_data
);
  logic [1:0] prev_gnt;
  logic [3:0] cnt;
  logic       full, keep1, m1_win, g0, g1;
  always_comb begin
    full = cnt == 4'(MAX_BURST);
`ifdef MEM_ARB_LOCK_EN
    keep1 = i_m1_lock;
`else
    keep1 = 1'b0;
`endif
    // On a tie: idle history goes to m0, the holder keeps the RAM until it
    // saturates, and then the RAM passes to the other master.
    m1_win = (i_m0_req & i_m1_req) ? (prev_gnt == 2'b10 ? (~full | keep1) : (prev_gnt == 2'b01 & full)) : i_m1_req;
    g1 = i_rst_n & m1_win;
    g0 = i_rst_n & i_m0_req & ~m1_win;
    o_m0_gnt = g0;
    o_m1_gnt = g1;
    o_m0_stall = i_rst_n & i_m0_req & ~g0;
    o_ram_ce = g0 | g1;
    o_ram_we = g0 ? i_m0_we : g1 ? i_m1_we : 1'b0;
    o_ram_addr = g0 ? i_m0_addr : g1 ? i_m1_addr : '0;
    o_ram_data = g0 ? i_m0_data : g1 ? i_m1_data : '0;
    o_ram_sel = g0 ? i_m0_sel : g1 ? i_m1_sel : 4'b0;
    o_m0_rdata = (g0 & ~i_m0_we) ? i_ram_data : '0;
    o_m1_rdata = (g1 & ~i_m1_we) ? i_ram_data : '0;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !(g0 | g1)) begin
      prev_gnt <= 2'b00;
      cnt <= 4'd0;
    end else begin
      cnt <= ({g1, g0} == prev_gnt) ? (full ? cnt : cnt + 4'd1) : 4'd1;
      prev_gnt <= {g1, g0};
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scoreboard bench for data_mem_arbiter with a behavioural RAM.
module tb_data_mem_arbiter;
  typedef struct {
    logic        g0, g1, st, ce;
    logic [31:0] addr, r0, r1;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_data, m1_addr, m1_data;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_gnt, m1_gnt, m0_stall, ram_ce, ram_we;
  logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_data, ram_rdata;
  logic [3:0]  ram_sel;
  logic [31:0] mem [64];
  exp_t        q [$];
  int          checks = 0, errors = 0;
  data_mem_arbiter #(.N_ADDR(32), .N_DATA(32), .MAX_BURST(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_data(m0_data), .i_m0_sel(m0_sel),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_data(m1_data), .i_m1_sel(m1_sel),
`ifdef MEM_ARB_LOCK_EN
    .i_m1_lock(m1_lock),
`endif
    .o_m0_gnt(m0_gnt), .o_m1_gnt(m1_gnt), .o_m0_rdata(m0_rdata), .o_m1_rdata(m1_rdata),
    .o_m0_stall(m0_stall), .o_ram_ce(ram_ce), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_data(ram_data), .o_ram_sel(ram_sel), .i_ram_data(ram_rdata)
  );
  always #5 clk = ~clk;
  assign ram_rdata = mem[ram_addr[7:2]];
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[4] <= 32'hDEADBEEF;
      mem[8] <= 32'hAAAABBBB;
    end else if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++) if (ram_sel[b]) mem[ram_addr[7:2]][8*b+:8] <= ram_data[8*b+:8];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic set0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    m0_req = req; m0_we = we; m0_addr = addr; m0_data = data; m0_sel = sel;
  endtask
  task automatic set1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    m1_req = req; m1_we = we; m1_addr = addr; m1_data = data; m1_sel = sel;
  endtask
  task automatic cyc(input string tag, input logic g0, input logic g1, input logic [31:0] r0, input logic [31:0] r1);
    exp_t e, o;
    e.g0 = g0; e.g1 = g1; e.r0 = r0; e.r1 = r1;
    e.st = rst_n & m0_req & ~g0;
    e.ce = g0 | g1;
    e.addr = g0 ? m0_addr : g1 ? m1_addr : 32'h0;
    q.push_back(e);
    @(negedge clk);
    o = q.pop_front();
    chk({tag, ".m0_gnt"}, {31'b0, m0_gnt}, {31'b0, o.g0});
    chk({tag, ".m1_gnt"}, {31'b0, m1_gnt}, {31'b0, o.g1});
    chk({tag, ".stall"}, {31'b0, m0_stall}, {31'b0, o.st});
    chk({tag, ".ce"}, {31'b0, ram_ce}, {31'b0, o.ce});
    chk({tag, ".addr"}, ram_addr, o.addr);
    chk({tag, ".m0_rdata"}, m0_rdata, o.r0);
    chk({tag, ".m1_rdata"}, m1_rdata, o.r1);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    set0(1, 0, 32'h10, 32'h0, 4'hf);
    set1(1, 0, 32'h10, 32'h0, 4'hf);
    rst_n = 1'b0;
    cyc("rst", 0, 0, 0, 0);
    cyc("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
  endtask
  localparam logic [31:0] BEEF = 32'hDEADBEEF;
  initial begin
    m1_lock = 1'b0;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();
    set0(1, 0, 32'h10, 32'h0, 4'hf);
    cyc("uncont", 1, 0, BEEF, 0);
    do_reset();
    set0(1, 0, 32'h10, 32'h0, 4'hf);
    set1(1, 0, 32'h10, 32'h0, 4'hf);
    for (int i = 0; i < 4; i++) cyc("burst_m0", 1, 0, BEEF, 0);
    for (int i = 0; i < 4; i++) cyc("burst_m1", 0, 1, 0, BEEF);
    cyc("burst_back", 1, 0, BEEF, 0);
    do_reset();
    set0(1, 0, 32'h10, 32'h0, 4'hf);
    set1(1, 0, 32'h10, 32'h0, 4'hf);
    for (int i = 0; i < 4; i++) cyc("pre_m0", 1, 0, BEEF, 0);
    cyc("pre_m1", 0, 1, 0, BEEF);
    cyc("pre_m1", 0, 1, 0, BEEF);
    rst_n = 1'b0;
    cyc("mid_rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc("post_m0", 1, 0, BEEF, 0);
    cyc("post_m1", 0, 1, 0, BEEF);
    do_reset();
    set0(1, 0, 32'h10, 32'h0, 4'hf);
    set1(1, 0, 32'h10, 32'h0, 4'hf);
    cyc("drop_m0", 1, 0, BEEF, 0);
    cyc("drop_m0", 1, 0, BEEF, 0);
    m0_req = 1'b0;
    cyc("drop_m1", 0, 1, 0, BEEF);
    m0_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc("drop_wait", 0, 1, 0, BEEF);
    cyc("drop_back", 1, 0, BEEF, 0);
    do_reset();
    set1(1, 1, 32'h20, 32'h12345678, 4'b0011);
    cyc("wr_m1", 0, 1, 0, 0);
    set1(0, 0, 0, 0, 0);
    set0(1, 0, 32'h20, 32'h0, 4'hf);
    cyc("rd_back", 1, 0, 32'hAAAA5678, 0);
`ifdef MEM_ARB_LOCK_EN
    do_reset();
    m1_lock = 1'b1;
    set1(1, 0, 32'h10, 32'h0, 4'hf);
    cyc("lock_first", 0, 1, 0, BEEF);
    set0(1, 0, 32'h10, 32'h0, 4'hf);
    for (int i = 0; i < 6; i++) cyc("lock_hold", 0, 1, 0, BEEF);
    m1_lock = 1'b0;
    cyc("lock_drop", 1, 0, BEEF, 0);
`endif
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    cyc("idle", 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
